// File: rtl/thermostat_ctrl.sv
// Single-zone thermostat: heat/cool/auto with deadband, hysteresis and min-on/min-off dwell.
// Optional fan purge after each run is enabled by defining THERMO_FAN_PURGE_EN.
module thermostat_ctrl #(
  parameter int TEMP_W  = 8,
  parameter int BAND    = 2,
  parameter int HYST    = 1,
  parameter int MIN_ON  = 4,
  parameter int MIN_OFF = 4,
  parameter int PURGE   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TEMP_W-1:0] user_temp_setting,
  input  logic [TEMP_W-1:0] indoor_temp,
  input  logic [1:0]        mode,
  output logic              heating,
  output logic              cooling,
  output logic              fan,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HEAT = 2'b01,
    S_COOL = 2'b10,
    S_REST = 2'b11
  } st_e;

  localparam int CNT_MAX = (MIN_ON > MIN_OFF) ? ((MIN_ON > PURGE) ? MIN_ON : PURGE)
                                              : ((MIN_OFF > PURGE) ? MIN_OFF : PURGE);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int EXT_W   = TEMP_W + 1;

  st_e              state_q, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             fan_next;

  // One extra bit so set+BAND and temp+BAND never wrap.
  logic [EXT_W-1:0] t_ext, s_ext;
  logic             heat_dem, cool_dem, heat_done, cool_done, heat_ok, cool_ok;

  assign t_ext     = {1'b0, indoor_temp};
  assign s_ext     = {1'b0, user_temp_setting};
  assign heat_dem  = (t_ext + EXT_W'(BAND)) < s_ext;
  assign cool_dem  = t_ext > (s_ext + EXT_W'(BAND));
  assign heat_done = t_ext >= (s_ext + EXT_W'(HYST));
  assign cool_done = (t_ext + EXT_W'(HYST)) <= s_ext;
  assign heat_ok   = mode[0];
  assign cool_ok   = mode[1];
  assign state     = state_q;

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE: begin
        if (heat_ok && heat_dem)      state_next = S_HEAT;
        else if (cool_ok && cool_dem) state_next = S_COOL;
      end
      S_HEAT: if (cnt >= CNT_W'(MIN_ON - 1) && (heat_done || !heat_ok)) state_next = S_REST;
      S_COOL: if (cnt >= CNT_W'(MIN_ON - 1) && (cool_done || !cool_ok)) state_next = S_REST;
      default: if (cnt == CNT_W'(MIN_OFF - 1)) state_next = S_IDLE;
    endcase
  end

  // Dwell counter restarts on every state change and saturates.
  always_comb begin
    cnt_next = '0;
    if (state_next == state_q) cnt_next = (&cnt) ? cnt : cnt + 1'b1;
  end

`ifdef THERMO_FAN_PURGE_EN
  // from_run remembers that the current REST followed a run, not a reset.
  logic from_run, from_run_next, purge_next;

  always_comb begin
    from_run_next = from_run;
    purge_next    = 1'b0;
    if (state_next == S_REST) begin
      if (state_q != S_REST) begin
        from_run_next = 1'b1;
        purge_next    = 1'b1;
      end else begin
        purge_next = from_run && (cnt_next < CNT_W'(PURGE));
      end
    end
    fan_next = (state_next == S_HEAT) || (state_next == S_COOL) || purge_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) from_run <= 1'b0;
    else          from_run <= from_run_next;
  end
`else
  always_comb begin
    fan_next = (state_next == S_HEAT) || (state_next == S_COOL);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_REST;
      cnt     <= '0;
      heating <= 1'b0;
      cooling <= 1'b0;
      fan     <= 1'b0;
    end else begin
      state_q <= state_next;
      cnt     <= cnt_next;
      heating <= (state_next == S_HEAT);
      cooling <= (state_next == S_COOL);
      fan     <= fan_next;
    end
  end

endmodule
